tm1638_responder: RTL and testbench
===================================

# tm1638_responder

Device-side (responder) model of the TM1638 serial interface: receives STB/SCLK/DIO from a TM1638 host controller, decodes data, address and display-control commands, holds the 16-byte display RAM and returns 4 key-scan bytes on read frames. Sits at the far end of the SIO link, used for FPGA board emulation and as a closed-loop partner for the host-side board controller in simulation. All pins are oversampled in the single system clock domain.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops per input pin (min 2).
- `clk` input 1: system clock, must be ≥ 8× SCLK frequency.
- `rst` input 1: reset, asynchronous, active-low.
- `stb` input 1: frame strobe from host, active-low.
- `sclk` input 1: serial clock from host, idles high.
- `dio_in` input 1: serial data from host.
- `dio_out` output 1: serial data to host (key bytes).
- `dio_oe` output 1: high while responder drives DIO.
- `key_data` input 32: key-scan bytes; byte k = `key_data[8k+7:8k]`.
- `disp_ram` output 128: display RAM; address a = `disp_ram[8a+7:8a]`.
- `display_on` output 1: display-control bit 3.
- `brightness` output 3: display-control bits 2:0.
- `frame_err` output 1: one-cycle pulse, frame ended on partial byte.

## Operation
- Pins pass through `SYNC_STAGES` flops; SCLK rise/fall and STB rise/fall detected on synced values.
- Bit order LSB first. Receive: shift synced DIO on SCLK rising edge; byte complete on 8th rise. Transmit: present next bit on each SCLK falling edge.
- STB falling → S_CMD, bit counter 0. STB rising from any state → S_IDLE, bit counter cleared, `dio_oe`=0; if bit counter ≠ 0, pulse `frame_err`. Partial byte discarded.
- S_CMD, on byte complete, decode bits[7:6]:
  - 2'b01 data command: latch `rd_mode`=bit1, `fixed_addr`=bit2 (persist across frames). If bit1=1: snapshot `key_data`, key byte index 0 → S_RDATA; else → S_IGNORE.
  - 2'b11 address command: `addr`=bits[3:0] → S_WDATA.
  - 2'b10 display control: `display_on`=bit3, `brightness`=bits[2:0] → S_IGNORE.
  - 2'b00: → S_IGNORE, no state change.
- S_WDATA, byte complete: `disp_ram[addr]`←byte; if `fixed_addr`=0, `addr`←addr+1 (4-bit, 15 wraps to 0).
- S_RDATA: on each SCLK fall, `dio_oe`=1, `dio_out`=snapshot bit (byte idx, bit idx); byte idx advances after 8th rise. After byte 3 completes → S_IGNORE, `dio_oe`=0, `dio_out`=0.
- S_IGNORE: clock bits, discard data until STB rises.
- Reset values: `dio_out`=0, `dio_oe`=0, `disp_ram`=0, `display_on`=0, `brightness`=0, `frame_err`=0; internal `addr`=0, `rd_mode`=0, `fixed_addr`=0, state S_IDLE.

## Timing
- Pin edge to detected edge: `SYNC_STAGES`+1 clk cycles.
- RAM write, command latch, `display_on`/`brightness` update: registered in the cycle after the 8th rising-edge detect.
- `dio_out` valid `SYNC_STAGES`+2 cycles after host SCLK fall; at `clk` ≥ 8× SCLK this is within the SCLK-low half-period.
- Simultaneous STB rise and 8th SCLK rise detect: byte completes and is applied first, then frame ends; no `frame_err`.
- SCLK edges while STB high: ignored.
- Reset mid-frame: immediate return to reset values; next frame requires a fresh STB fall.

## Structure
- Package `tm1638_pkg`: command-type codes (CMD_DATA=2'b01, CMD_DISP=2'b10, CMD_ADDR=2'b11), data-command bit positions (READ=1, FIXED=2), display-control fields, state enum (S_IDLE, S_CMD, S_WDATA, S_RDATA, S_IGNORE). Shared with the host-side controller.
- Sub-module `tm1638_pin_sync`: N-stage synchronizer plus rise/fall edge pulses, instanced for `stb`, `sclk`, `dio_in`.

## Test plan
- Frame 0x40, then frame 0xC0 + bytes 0x3F,0x06,0x5B → `disp_ram` bytes 0..2 = 0x3F,0x06,0x5B; others 0.
- Frame 0x44, frame 0xC5 + 0x11,0x22 → address 5 = 0x22, address 6 unchanged.
- Frame 0x40, frame 0xCF + 0xAA,0xBB → address 15 = 0xAA, address 0 = 0xBB (wrap).
- Frame 0x8C → `display_on`=1, `brightness`=3'd4; frame 0x80 → `display_on`=0.
- `key_data`=0x8040_2001, frame 0x42 + 4 read bytes → host receives 0x01,0x20,0x40,0x80 LSB first; `dio_oe` falls after byte 3 or at STB rise.
- STB rises after 5 bits of 0xC0 frame → `frame_err` pulses one cycle, RAM and `addr` unchanged.

Source files
------------

// File: rtl/tm1638_pkg.sv
// Shared TM1638 protocol definitions: command-type codes, command bit
// positions, responder state encoding and the pin-event bundle.
package tm1638_pkg;

  localparam int unsigned KEY_BYTES = 4;
  localparam int unsigned RAM_BYTES = 16;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned BRIGHT_W  = 3;

  // Command type lives in byte bits [7:6]
  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_DATA = 2'b01,
    CMD_DISP = 2'b10,
    CMD_ADDR = 2'b11
  } cmd_t;

  // Data-command bit positions
  localparam int unsigned DATA_READ_BIT  = 1;
  localparam int unsigned DATA_FIXED_BIT = 2;

  // Display-control fields: bit 3 = on, bits 2:0 = brightness
  localparam int unsigned DISP_ON_BIT = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WDATA,
    S_RDATA,
    S_IGNORE
  } state_t;

  // Synchronized pin level with edge pulses, all aligned to the same cycle
  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } pin_ev_t;

endpackage

// File: rtl/tm1638_responder_if.sv
// TM1638 serial link (STB/SCLK/DIO). The host drives stb, sclk, dio_in;
// the responder drives dio_out and dio_oe.
interface tm1638_responder_if;
  logic stb;
  logic sclk;
  logic dio_in;
  logic dio_out;
  logic dio_oe;

  modport master (output stb, sclk, dio_in, input dio_out, dio_oe);
  modport slave  (input stb, sclk, dio_in, output dio_out, dio_oe);
endinterface

// File: rtl/tm1638_pin_sync.sv
// N-stage synchronizer with registered rise/fall pulses.
// Ports: clk, rst (async active-low), d (async pin), ev (level/rise/fall,
// all SYNC_STAGES+1 cycles behind the pin).
module tm1638_pin_sync
  import tm1638_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
)
(
  input  logic    clk,
  input  logic    rst,
  input  logic    d,
  output pin_ev_t ev
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;

  // level_q is the previous synced value, so it lines up with the pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= {SYNC_STAGES{RST_VAL}};
      level_q <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], d};
      level_q <= sync_q[SYNC_STAGES-1];
      rise_q  <= sync_q[SYNC_STAGES-1] & ~level_q;
      fall_q  <= ~sync_q[SYNC_STAGES-1] & level_q;
    end
  end

  assign ev.level = level_q;
  assign ev.rise  = rise_q;
  assign ev.fall  = fall_q;

endmodule

// File: rtl/tm1638_responder.sv
// TM1638 device-side responder: decodes host frames, holds the 16-byte
// display RAM and display control, returns 4 key bytes on read frames.
// Ports: clk, rst (async active-low), sio (serial link, slave side),
// key_data (key bytes in), disp_ram, display_on, brightness,
// frame_err (one-cycle pulse when a frame ends on a partial byte).
module tm1638_responder
  import tm1638_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
)
(
  input  logic                     clk,
  input  logic                     rst,
  tm1638_responder_if.slave        sio,
  input  logic [KEY_BYTES*8-1:0]   key_data,
  output logic [RAM_BYTES*8-1:0]   disp_ram,
  output logic                     display_on,
  output logic [BRIGHT_W-1:0]      brightness,
  output logic                     frame_err
);

  localparam int unsigned BIT_W  = 3;
  localparam int unsigned KIDX_W = 2;

  pin_ev_t stb_ev, sclk_ev, dio_ev;

  tm1638_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_stb_sync
    (.clk(clk), .rst(rst), .d(sio.stb),    .ev(stb_ev));
  tm1638_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync
    (.clk(clk), .rst(rst), .d(sio.sclk),   .ev(sclk_ev));
  tm1638_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_dio_sync
    (.clk(clk), .rst(rst), .d(sio.dio_in), .ev(dio_ev));

  logic unused_ev;
  assign unused_ev = &{1'b0, stb_ev.level, sclk_ev.level, dio_ev.rise, dio_ev.fall};

  state_t                    state_q, state_d;
  logic [BIT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [6:0]                shift_q, shift_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic                      rd_mode_q, rd_mode_d;
  logic                      fixed_q, fixed_d;
  logic [RAM_BYTES*8-1:0]    ram_q, ram_d;
  logic                      on_q, on_d;
  logic [BRIGHT_W-1:0]       bright_q, bright_d;
  logic [KEY_BYTES*8-1:0]    snap_q, snap_d;
  logic [KIDX_W-1:0]         kidx_q, kidx_d;
  logic                      dio_out_q, dio_out_d;
  logic                      dio_oe_q, dio_oe_d;
  logic                      ferr_q, ferr_d;
  logic [7:0]                byte_val;
  logic                      byte_done;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      rd_mode_q <= 1'b0;
      fixed_q   <= 1'b0;
      ram_q     <= '0;
      on_q      <= 1'b0;
      bright_q  <= '0;
      snap_q    <= '0;
      kidx_q    <= '0;
      dio_out_q <= 1'b0;
      dio_oe_q  <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      rd_mode_q <= rd_mode_d;
      fixed_q   <= fixed_d;
      ram_q     <= ram_d;
      on_q      <= on_d;
      bright_q  <= bright_d;
      snap_q    <= snap_d;
      kidx_q    <= kidx_d;
      dio_out_q <= dio_out_d;
      dio_oe_q  <= dio_oe_d;
      ferr_q    <= ferr_d;
    end
  end

  // Frame decode: byte assembly, command handling, key transmit, frame end
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    rd_mode_d = rd_mode_q;
    fixed_d   = fixed_q;
    ram_d     = ram_q;
    on_d      = on_q;
    bright_d  = bright_q;
    snap_d    = snap_q;
    kidx_d    = kidx_q;
    dio_out_d = dio_out_q;
    dio_oe_d  = dio_oe_q;
    ferr_d    = 1'b0;
    // LSB first: the newest bit lands in bit 7 and shifts down
    byte_val  = {dio_ev.level, shift_q};
    byte_done = 1'b0;

    if (stb_ev.fall) begin
      state_d   = S_CMD;
      bit_cnt_d = '0;
    end else if (state_q != S_IDLE) begin
      if (sclk_ev.rise) begin
        shift_d   = byte_val[7:1];
        bit_cnt_d = bit_cnt_q + 3'd1;
        byte_done = (bit_cnt_q == 3'd7);
      end

      if (sclk_ev.fall && state_q == S_RDATA) begin
        dio_oe_d  = 1'b1;
        dio_out_d = snap_q[{kidx_q, bit_cnt_q}];
      end

      if (byte_done) begin
        unique case (state_q)
          S_CMD: begin
            unique case (cmd_t'(byte_val[7:6]))
              CMD_DATA: begin
                rd_mode_d = byte_val[DATA_READ_BIT];
                fixed_d   = byte_val[DATA_FIXED_BIT];
                if (rd_mode_d) begin
                  snap_d  = key_data;
                  kidx_d  = '0;
                  state_d = S_RDATA;
                end else begin
                  state_d = S_IGNORE;
                end
              end
              CMD_ADDR: begin
                addr_d  = byte_val[ADDR_W-1:0];
                state_d = S_WDATA;
              end
              CMD_DISP: begin
                on_d     = byte_val[DISP_ON_BIT];
                bright_d = byte_val[BRIGHT_W-1:0];
                state_d  = S_IGNORE;
              end
              default: state_d = S_IGNORE;
            endcase
          end
          S_WDATA: begin
            ram_d[{addr_q, 3'b000} +: 8] = byte_val;
            if (!fixed_q) addr_d = addr_q + 4'd1;
          end
          S_RDATA: begin
            if (kidx_q == 2'd3) begin
              state_d   = S_IGNORE;
              dio_oe_d  = 1'b0;
              dio_out_d = 1'b0;
            end else begin
              kidx_d = kidx_q + 2'd1;
            end
          end
          default: ;
        endcase
      end

      // A byte finishing on this same edge leaves the counter at zero
      if (stb_ev.rise) begin
        ferr_d    = (bit_cnt_d != 3'd0);
        state_d   = S_IDLE;
        bit_cnt_d = '0;
        dio_oe_d  = 1'b0;
        dio_out_d = 1'b0;
      end
    end
  end

  assign sio.dio_out = dio_out_q;
  assign sio.dio_oe  = dio_oe_q;
  assign disp_ram    = ram_q;
  assign display_on  = on_q;
  assign brightness  = bright_q;
  assign frame_err   = ferr_q;

endmodule

// File: tb/tb_tm1638_responder.sv
// Bench for tm1638_responder: a host-side bit-banger drives frames, and a
// frame-level model of display RAM / display control / key readback
// supplies the expected values.
module tb_tm1638_responder;

  localparam int HALF = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  key_data;
  logic [127:0] disp_ram;
  logic         display_on;
  logic [2:0]   brightness;
  logic         frame_err;

  always #5 clk = ~clk;

  tm1638_responder_if sio();

  tm1638_responder #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .sio        (sio.slave),
    .key_data   (key_data),
    .disp_ram   (disp_ram),
    .display_on (display_on),
    .brightness (brightness),
    .frame_err  (frame_err)
  );

  int total = 0;
  int bad   = 0;
  int fe_count = 0;
  int fe_exp   = 0;

  // Reference state
  logic [7:0] mem [16];
  bit         m_fixed;
  bit         m_on;
  logic [2:0] m_bright;

  logic [7:0]  q[$];
  logic [31:0] got;
  logic [31:0] key;
  logic [3:0]  oe_ok;

  // Cycles with frame_err high; a clean pulse adds exactly one
  always @(negedge clk) if (frame_err === 1'b1) fe_count++;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    foreach (mem[i]) mem[i] = 8'h00;
    m_fixed  = 1'b0;
    m_on     = 1'b0;
    m_bright = 3'd0;
  endtask

  // Frame-level effect of a sequence of complete bytes
  task automatic model_frame(input logic [7:0] bq[$]);
    int a;
    if (bq.size() == 0) return;
    case (bq[0][7:6])
      2'b01: m_fixed = bq[0][2];
      2'b11: begin
        a = int'(bq[0][3:0]);
        for (int i = 1; i < bq.size(); i++) begin
          mem[a] = bq[i];
          if (!m_fixed) a = (a + 1) % 16;
        end
      end
      2'b10: begin
        m_on     = bq[0][3];
        m_bright = bq[0][2:0];
      end
      default: ;
    endcase
  endtask

  function automatic logic [127:0] model_ram();
    logic [127:0] r;
    for (int a = 0; a < 16; a++) r[8*a +: 8] = mem[a];
    return r;
  endfunction

  task automatic send_bits(input logic [7:0] b, input int nbits, input bit end_on_last);
    for (int i = 0; i < nbits; i++) begin
      sio.sclk   = 1'b0;
      sio.dio_in = b[i];
      wait_clk(HALF);
      sio.sclk = 1'b1;
      if (end_on_last && i == nbits - 1) sio.stb = 1'b1;
      wait_clk(HALF);
    end
  endtask

  task automatic frame(input logic [7:0] bq[$], input logic [7:0] tail_val,
                       input int tail_bits, input bit sim_end);
    sio.stb = 1'b0;
    wait_clk(HALF);
    foreach (bq[i]) send_bits(bq[i], 8, sim_end && tail_bits == 0 && i == bq.size() - 1);
    if (tail_bits > 0) send_bits(tail_val, tail_bits, 1'b0);
    wait_clk(HALF);
    sio.stb    = 1'b1;
    sio.dio_in = 1'b0;
    wait_clk(2 * HALF);
  endtask

  task automatic do_frame(input string tag, input logic [7:0] bq[$], input logic [7:0] tail_val,
                          input int tail_bits, input bit sim_end);
    model_frame(bq);
    if (tail_bits > 0) fe_exp++;
    frame(bq, tail_val, tail_bits, sim_end);
    check({tag, "_ram"},  disp_ram, model_ram());
    check({tag, "_disp"}, 128'({display_on, brightness}), 128'({m_on, m_bright}));
    check({tag, "_ferr"}, 128'(fe_count), 128'(fe_exp));
  endtask

  task automatic one_byte_frame(input string tag, input logic [7:0] b);
    logic [7:0] bq[$];
    bq.push_back(b);
    do_frame(tag, bq, 8'h00, 0, 1'b0);
  endtask

  // Read command then nbytes key bytes; key_data is changed after the command
  // byte so only the snapshot can produce the right answer. Leaves STB low.
  task automatic read_frame(input bit fixed, input int nbytes, input logic [31:0] key_after,
                            output logic [31:0] rd, output logic [3:0] oe);
    sio.stb = 1'b0;
    wait_clk(HALF);
    send_bits(8'h42 | (fixed ? 8'h04 : 8'h00), 8, 1'b0);
    m_fixed  = fixed;
    key_data = key_after;
    rd = '0;
    oe = '1;
    for (int k = 0; k < nbytes; k++) begin
      for (int i = 0; i < 8; i++) begin
        sio.sclk = 1'b0;
        wait_clk(HALF);
        rd[8*k + i] = sio.dio_out;
        if (sio.dio_oe !== 1'b1) oe[k] = 1'b0;
        sio.sclk = 1'b1;
        wait_clk(HALF);
      end
    end
  endtask

  initial begin
    int n;
    int tail;
    bit fx;
    logic [7:0] tv;

    sio.stb    = 1'b1;
    sio.sclk   = 1'b1;
    sio.dio_in = 1'b0;
    key_data   = 32'h0;
    rst        = 1'b0;
    model_reset();
    wait_clk(5);
    check("rst_ram",  disp_ram, 128'h0);
    check("rst_pins", 128'({sio.dio_out, sio.dio_oe, frame_err}), 128'(3'b000));
    check("rst_disp", 128'({display_on, brightness}), 128'(4'h0));
    rst = 1'b1;
    wait_clk(5);

    // Auto-increment write from address 0
    one_byte_frame("tp1_dc", 8'h40);
    q = '{8'hC0, 8'h3F, 8'h06, 8'h5B};
    do_frame("tp1", q, 8'h00, 0, 1'b0);
    check("tp1_b012", 128'(disp_ram[23:0]), 128'(24'h5B063F));
    check("tp1_rest", 128'(disp_ram[127:24]), 128'h0);

    // Fixed address: second byte overwrites the first
    one_byte_frame("tp2_dc", 8'h44);
    q = '{8'hC5, 8'h11, 8'h22};
    do_frame("tp2", q, 8'h00, 0, 1'b0);
    check("tp2_a5", 128'(disp_ram[47:40]), 128'(8'h22));
    check("tp2_a6", 128'(disp_ram[55:48]), 128'(8'h00));

    // Address wraps 15 -> 0
    one_byte_frame("tp3_dc", 8'h40);
    q = '{8'hCF, 8'hAA, 8'hBB};
    do_frame("tp3", q, 8'h00, 0, 1'b0);
    check("tp3_a15", 128'(disp_ram[127:120]), 128'(8'hAA));
    check("tp3_a0",  128'(disp_ram[7:0]), 128'(8'hBB));

    // Display control
    one_byte_frame("tp4_on", 8'h8C);
    check("tp4_on_val", 128'({display_on, brightness}), 128'({1'b1, 3'd4}));
    one_byte_frame("tp4_off", 8'h80);
    check("tp4_off_val", 128'(display_on), 128'(1'b0));

    // Key read, all four bytes
    key_data = 32'h8040_2001;
    read_frame(1'b0, 4, 32'h1234_5678, got, oe_ok);
    check("tp5_keys", 128'(got), 128'({8'h80, 8'h40, 8'h20, 8'h01}));
    check("tp5_oe", 128'(oe_ok), 128'(4'hF));
    wait_clk(HALF);
    check("tp5_oe_end", 128'({sio.dio_oe, sio.dio_out}), 128'(2'b00));
    sio.stb = 1'b1;
    wait_clk(2 * HALF);
    check("tp5_ferr", 128'(fe_count), 128'(fe_exp));

    // Partial command byte: error pulse, nothing written
    q.delete();
    do_frame("tp6", q, 8'hC0, 5, 1'b0);

    // STB rises together with the 8th SCLK rise: byte lands, no error
    one_byte_frame("sim_dc", 8'h40);
    q = '{8'hC3, 8'h5A};
    do_frame("sim", q, 8'h00, 0, 1'b1);
    check("sim_a3", 128'(disp_ram[31:24]), 128'(8'h5A));

    // STB rise in the middle of a read releases DIO
    key_data = 32'hCAFE_BEEF;
    read_frame(1'b0, 2, 32'h0, got, oe_ok);
    check("mid_keys", 128'(got[15:0]), 128'(16'hBEEF));
    check("mid_oe", 128'(oe_ok[1:0]), 128'(2'b11));
    sio.stb = 1'b1;
    wait_clk(2 * HALF);
    check("mid_oe_off", 128'(sio.dio_oe), 128'(1'b0));
    check("mid_ferr", 128'(fe_count), 128'(fe_exp));

    // Reset in the middle of a frame, with fixed mode set beforehand
    one_byte_frame("rm_dc", 8'h44);
    one_byte_frame("rm_on", 8'h8F);
    sio.stb = 1'b0;
    wait_clk(HALF);
    send_bits(8'hC0, 3, 1'b0);
    rst      = 1'b0;
    sio.stb  = 1'b1;
    sio.sclk = 1'b1;
    wait_clk(4);
    model_reset();
    check("rm_ram", disp_ram, 128'h0);
    check("rm_disp", 128'({display_on, brightness}), 128'(4'h0));
    check("rm_pins", 128'({sio.dio_oe, sio.dio_out, frame_err}), 128'(3'b000));
    rst = 1'b1;
    wait_clk(5);
    q = '{8'hC2, 8'h77, 8'h88};
    do_frame("rm_wr", q, 8'h00, 0, 1'b0);

    // Randomized frames against the model
    for (int it = 0; it < 20; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          fx = 1'($urandom_range(0, 1));
          one_byte_frame("rnd_dc", 8'h40 | (fx ? 8'h04 : 8'h00));
          q.delete();
          q.push_back(8'hC0 | 8'($urandom_range(0, 15)));
          n = $urandom_range(1, 6);
          for (int j = 0; j < n; j++) q.push_back(8'($urandom));
          tail = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
          tv = 8'($urandom);
          do_frame("rnd_wr", q, tv, tail, 1'b0);
        end
        1: begin
          key = $urandom;
          key_data = key;
          fx = 1'($urandom_range(0, 1));
          read_frame(fx, 4, $urandom, got, oe_ok);
          check("rnd_keys", 128'(got), 128'(key));
          check("rnd_oe", 128'(oe_ok), 128'(4'hF));
          sio.stb = 1'b1;
          wait_clk(2 * HALF);
          check("rnd_rd_ferr", 128'(fe_count), 128'(fe_exp));
        end
        2: one_byte_frame("rnd_disp", 8'h80 | 8'($urandom_range(0, 15)));
        default: begin
          q.delete();
          tv = 8'($urandom);
          do_frame("rnd_part", q, tv, $urandom_range(1, 7), 1'b0);
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
